// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : Shared pipeline constants for the HI/LO multiply/divide path.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    // E_MulDivOp encodings, shared with the decoder
    localparam logic [3:0] c_OP_NONE  = 4'd0;
    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    localparam int c_MUL_CYCLES = 5;
    localparam int c_DIV_CYCLES = 10;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == c_OP_MULT) || (op == c_OP_MULTU) ||
               (op == c_OP_DIV)  || (op == c_OP_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == c_OP_MULT) || (op == c_OP_MULTU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_md_arith.sv
`default_nettype none
// ============================================================================
// Module      : md_arith
// Description : Combinational 32-bit multiply / divide producing HI, LO, div0.
// Revision    : 1.0 - initial release
// ============================================================================
module md_arith
    import mul_div_unit_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide runs on magnitudes; 0x80000000 negates to itself, which
    // yields the required 0x80000000 / -1 = 0x80000000 wrap.
    assign w_signed_div = (i_op == c_OP_DIV);
    assign w_a_neg      = w_signed_div && i_a[31];
    assign w_b_neg      = w_signed_div && i_b[31];
    assign w_abs_a      = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_abs_b      = w_b_neg ? (32'd0 - i_b) : i_b;
    assign w_div_b      = (i_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_uq         = w_abs_a / w_div_b;
    assign w_ur         = w_abs_a % w_div_b;
    assign w_quo        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    assign w_rem        = w_a_neg ? (32'd0 - w_ur) : w_ur;

    assign o_div0 = ((i_op == c_OP_DIV) || (i_op == c_OP_DIVU)) && (i_b == 32'd0);

    always_comb begin
        o_hi = 32'd0;
        o_lo = 32'd0;
        case (i_op)
            c_OP_MULT: begin
                o_hi = w_prod_s[63:32];
                o_lo = w_prod_s[31:0];
            end
            c_OP_MULTU: begin
                o_hi = w_prod_u[63:32];
                o_lo = w_prod_u[31:0];
            end
            c_OP_DIV, c_OP_DIVU: begin
                o_hi = w_rem;
                o_lo = w_quo;
            end
            default: begin
                o_hi = 32'd0;
                o_lo = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit with shadow commit.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int MUL_CYCLES = c_MUL_CYCLES,
    parameter int DIV_CYCLES = c_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  E_MulDivOp,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] MD_Out
);

    localparam int c_CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_sh_hi;
    logic [31:0]        r_sh_lo;
    logic               r_sh_div0;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;

    logic [31:0]        w_arith_hi;
    logic [31:0]        w_arith_lo;
    logic               w_arith_div0;

    md_arith u_md_arith (
        .i_op   (E_MulDivOp),
        .i_a    (E_RS),
        .i_b    (E_RT),
        .o_hi   (w_arith_hi),
        .o_lo   (w_arith_lo),
        .o_div0 (w_arith_div0)
    );

    assign Start = is_md_op(E_MulDivOp) && !r_busy;
    assign Busy  = r_busy;

    always_comb begin
        MD_Out = 32'd0;
        case (E_MulDivOp)
            c_OP_MFHI: MD_Out = r_hi;
            c_OP_MFLO: MD_Out = r_lo;
            default:   MD_Out = 32'd0;
        endcase
    end

    // While busy every op except the (combinational) reads is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_sh_hi   <= 32'd0;
            r_sh_lo   <= 32'd0;
            r_sh_div0 <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (r_cnt == c_CNT_W'(1)) begin
                r_busy <= 1'b0;
                if (!r_sh_div0) begin
                    r_hi <= r_sh_hi;
                    r_lo <= r_sh_lo;
                end
            end
        end else if (Start) begin
            r_sh_hi   <= w_arith_hi;
            r_sh_lo   <= w_arith_lo;
            r_sh_div0 <= w_arith_div0;
            r_busy    <= 1'b1;
            r_cnt     <= is_mult_op(E_MulDivOp) ? c_CNT_W'(MUL_CYCLES) : c_CNT_W'(DIV_CYCLES);
        end else if (E_MulDivOp == c_OP_MTHI) begin
            r_hi <= E_RS;
        end else if (E_MulDivOp == c_OP_MTLO) begin
            r_lo <= E_RS;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Scoreboard bench for mul_div_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam logic [3:0] c_NONE  = 4'd0;
    localparam logic [3:0] c_MULT  = 4'd1;
    localparam logic [3:0] c_MULTU = 4'd2;
    localparam logic [3:0] c_DIV   = 4'd3;
    localparam logic [3:0] c_DIVU  = 4'd4;
    localparam logic [3:0] c_MFHI  = 4'd5;
    localparam logic [3:0] c_MFLO  = 4'd6;
    localparam logic [3:0] c_MTHI  = 4'd7;
    localparam logic [3:0] c_MTLO  = 4'd8;

    typedef struct {
        logic        start;
        logic        busy;
        logic [31:0] md;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  E_MulDivOp;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic        Start;
    logic        Busy;
    logic [31:0] MD_Out;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    mul_div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .E_MulDivOp (E_MulDivOp),
        .E_RS       (E_RS),
        .E_RT       (E_RT),
        .Start      (Start),
        .Busy       (Busy),
        .MD_Out     (MD_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, got, want, $time);
    endfunction

    // Monitor: one expectation per clock, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("start",  {31'd0, Start}, {31'd0, e.start});
                check("busy",   {31'd0, Busy},  {31'd0, e.busy});
                check("md_out", MD_Out,         e.md);
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic s, input logic b, input logic [31:0] md);
        exp_t e;
        rst        = r;
        E_MulDivOp = op;
        E_RS       = rs;
        E_RT       = rt;
        e.start    = s;
        e.busy     = b;
        e.md       = md;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic busy_run(input int n, input logic [3:0] op, input logic [31:0] md);
        for (int i = 0; i < n; i++) step(1'b0, op, 32'd0, 32'd0, 1'b0, 1'b1, md);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        E_MulDivOp = c_NONE;
        E_RS       = 32'd0;
        E_RT       = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and reset priority over a start
        step(1, c_MULT, 32'd2, 32'd3, 1, 0, 32'd0);
        step(1, c_MFHI, 0, 0, 0, 0, 32'd0);
        step(0, 4'd9,   0, 0, 0, 0, 32'd0);
        step(0, c_MFLO, 0, 0, 0, 0, 32'd0);

        // MULT -2 * 3
        step(0, c_MULT, 32'hFFFF_FFFE, 32'd3, 1, 0, 32'd0);
        busy_run(5, c_MFHI, 32'd0);
        step(0, c_MFHI, 0, 0, 0, 0, 32'hFFFF_FFFF);
        step(0, c_MFLO, 0, 0, 0, 0, 32'hFFFF_FFFA);

        // MULTU max * max
        step(0, c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'd0);
        busy_run(5, c_NONE, 32'd0);
        step(0, c_MFHI, 0, 0, 0, 0, 32'hFFFF_FFFE);
        step(0, c_MFLO, 0, 0, 0, 0, 32'h0000_0001);

        // DIV -7 / 2
        step(0, c_DIV, 32'hFFFF_FFF9, 32'd2, 1, 0, 32'd0);
        busy_run(10, c_MFLO, 32'h0000_0001);
        step(0, c_MFLO, 0, 0, 0, 0, 32'hFFFF_FFFD);
        step(0, c_MFHI, 0, 0, 0, 0, 32'hFFFF_FFFF);

        // DIVU 7 / 0 with an MTLO slipped in: nothing may change
        step(0, c_DIVU, 32'd7, 32'd0, 1, 0, 32'd0);
        busy_run(2, c_NONE, 32'd0);
        step(0, c_MTLO, 32'h0000_BEEF, 0, 0, 1, 32'd0);
        busy_run(7, c_NONE, 32'd0);
        step(0, c_MFHI, 0, 0, 0, 0, 32'hFFFF_FFFF);
        step(0, c_MFLO, 0, 0, 0, 0, 32'hFFFF_FFFD);

        // DIV 100 / 7 with MULT and MTLO in busy cycles 3 and 4
        step(0, c_DIV, 32'd100, 32'd7, 1, 0, 32'd0);
        busy_run(2, c_NONE, 32'd0);
        step(0, c_MULT, 32'd5, 32'd5, 0, 1, 32'd0);
        step(0, c_MTLO, 32'h0000_BEEF, 0, 0, 1, 32'd0);
        busy_run(6, c_NONE, 32'd0);
        step(0, c_MFLO, 0, 0, 0, 0, 32'd14);
        step(0, c_MFHI, 0, 0, 0, 0, 32'd2);

        // DIV overflow case
        step(0, c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'd0);
        busy_run(10, c_NONE, 32'd0);
        step(0, c_MFLO, 0, 0, 0, 0, 32'h8000_0000);
        step(0, c_MFHI, 0, 0, 0, 0, 32'd0);

        // DIVU max / 10
        step(0, c_DIVU, 32'hFFFF_FFFF, 32'd10, 1, 0, 32'd0);
        busy_run(10, c_NONE, 32'd0);
        step(0, c_MFHI, 0, 0, 0, 0, 32'd5);
        step(0, c_MFLO, 0, 0, 0, 0, 32'h1999_9999);

        // MTLO when idle
        step(0, c_MTLO, 32'hA5A5_A5A5, 0, 0, 0, 32'd0);
        step(0, c_MFLO, 0, 0, 0, 0, 32'hA5A5_A5A5);

        // Reset aborts a MULT at busy cycle 3
        step(0, c_MULT, 32'd3, 32'd4, 1, 0, 32'd0);
        busy_run(2, c_NONE, 32'd0);
        step(1, c_NONE, 0, 0, 0, 1, 32'd0);
        step(0, c_MTHI, 32'h1234_5678, 0, 0, 0, 32'd0);
        step(0, c_MFLO, 0, 0, 0, 0, 32'd0);
        step(0, c_MFHI, 0, 0, 0, 0, 32'h1234_5678);
        for (int i = 0; i < 6; i++) step(0, c_NONE, 0, 0, 0, 0, 32'd0);
        step(0, c_MFLO, 0, 0, 0, 0, 32'd0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
